// File: rtl/common.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// counter widths and the protocol interval constants derived from CLK_FREQ.
package common;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAITIDLE,
    DONE
  } ps2_tx_state_t;

  // Interval / watchdog counter width; 19 bits covers the 15 ms watchdog at 28 MHz.
  localparam int CNT_W     = 19;
  // Bit counter width and the count at which the stop bit goes out.
  localparam int BIT_CNT_W = 4;
  localparam int LAST_BIT  = 10;
  // Number of equal consecutive samples before the filtered line moves.
  localparam int FILT_LEN  = 4;

  // 100 us clock inhibit before the request-to-send.
  function automatic int inhibit_cycles(input int clk_freq);
    return clk_freq / 10000;
  endfunction

  // 1 us of start bit with the clock still held low.
  function automatic int rts_cycles(input int clk_freq);
    return clk_freq / 1_000_000;
  endfunction

  // 15 ms from clock release until the ack must have been captured.
  function automatic int ack_timeout_cycles(input int clk_freq);
    return int'((longint'(clk_freq) * 15) / 1000);
  endfunction

  // 2 ms for the device to release both lines after the ack.
  function automatic int idle_timeout_cycles(input int clk_freq);
    return int'((longint'(clk_freq) * 2) / 1000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, a stability filter that
// only moves after FILT_LEN equal consecutive samples, and a registered
// falling-edge strobe of the filtered value. Shared with the PS/2 receiver.
module ps2_line_filter
  import common::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic filt,
  output logic fall
);

  localparam int RUN_W = $clog2(FILT_LEN);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic             fall_q,  fall_d;
  logic [RUN_W-1:0] run_q,   run_d;

  // Synchronize the pin and count how long it has disagreed with the filtered value.
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fall_d  = 1'b0;
    run_d   = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RUN_W'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
        fall_d = filt_q & ~sync2_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  // Idle PS/2 lines float high, so everything resets to 1 except the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      run_q   <= run_d;
    end
  end

  assign filt = filt_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the clock, issues request-to-send,
// then shifts start/data/parity/stop on device clock falls and samples the ack.
// Optional watchdogs on the device-clocked phases: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import common::*;
#(
  parameter int CLK_FREQ = 28_000_000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INHIBIT_CYC = inhibit_cycles(CLK_FREQ);
  localparam int RTS_CYC     = rts_cycles(CLK_FREQ);
`ifdef PS2_TX_TIMEOUT_EN
  localparam int ACK_TO_CYC  = ack_timeout_cycles(CLK_FREQ);
  localparam int IDLE_TO_CYC = idle_timeout_cycles(CLK_FREQ);
`endif

  ps2_tx_state_t        state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]           shift_q,   shift_d;
  logic                 dat_q,     dat_d;
  logic                 ack_n_q,   ack_n_d;

  logic clk_filt, clk_fall;
  logic dat_filt, dat_fall_unused;
  logic wd_expired;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + BIT_CNT_W'(1);
  endfunction

  ps2_line_filter u_clk_filt (
    .clk    (clk28),
    .rst_n  (rst_n),
    .pin_in (ps2_clk_in),
    .filt   (clk_filt),
    .fall   (clk_fall)
  );

  ps2_line_filter u_dat_filt (
    .clk    (clk28),
    .rst_n  (rst_n),
    .pin_in (ps2_dat_in),
    .filt   (dat_filt),
    .fall   (dat_fall_unused)
  );

  // Watchdog fires when the shared interval counter runs out in a device-clocked state.
`ifdef PS2_TX_TIMEOUT_EN
  assign wd_expired = (cnt_q == '0);
`else
  assign wd_expired = 1'b0;
`endif

  // State and datapath registers; lines are released as soon as reset asserts.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dat_q     <= 1'b1;
      ack_n_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dat_q     <= dat_d;
      ack_n_q   <= ack_n_d;
    end
  end

  // Next state plus the shift register, bit counter and interval counter updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dat_d     = dat_q;
    ack_n_d   = ack_n_q;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          // Parity sits above d7 so it falls out of the shifter right after it.
          shift_d = {~^tx_data, tx_data};
          cnt_d   = CNT_W'(INHIBIT_CYC - 1);
          ack_n_d = 1'b0;
          dat_d   = 1'b1;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(RTS_CYC - 1);
          dat_d   = 1'b0;
          state_d = RTS;
        end else begin
          cnt_d = sat_dec(cnt_q);
        end
      end
      RTS: begin
        if (cnt_q == '0) begin
          bit_cnt_d = '0;
`ifdef PS2_TX_TIMEOUT_EN
          cnt_d     = CNT_W'(ACK_TO_CYC - 1);
`endif
          state_d   = SHIFT;
        end else begin
          cnt_d = sat_dec(cnt_q);
        end
      end
      SHIFT: begin
        cnt_d = sat_dec(cnt_q);
        if (wd_expired) begin
          ack_n_d = 1'b1;
          dat_d   = 1'b1;
          state_d = DONE;
        end else if (clk_fall) begin
          // Ones are shifted in behind the byte, so the 10th bit is the stop bit.
          bit_cnt_d = sat_inc(bit_cnt_q);
          dat_d     = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          if (bit_cnt_d == BIT_CNT_W'(LAST_BIT)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        cnt_d = sat_dec(cnt_q);
        if (wd_expired) begin
          ack_n_d = 1'b1;
          state_d = DONE;
        end else if (clk_fall) begin
          ack_n_d = dat_filt;
`ifdef PS2_TX_TIMEOUT_EN
          cnt_d   = CNT_W'(IDLE_TO_CYC - 1);
`endif
          state_d = WAITIDLE;
        end
      end
      WAITIDLE: begin
        cnt_d = sat_dec(cnt_q);
        if (clk_filt && dat_filt) begin
          state_d = DONE;
        end else if (wd_expired) begin
          ack_n_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        dat_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin drives and status flags decoded from the current state.
  always_comb begin
    ps2_clk_out = 1'b1;
    ps2_dat_out = 1'b1;
    tx_busy     = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    unique case (state_q)
      INHIBIT: begin
        ps2_clk_out = 1'b0;
        tx_busy     = 1'b1;
      end
      RTS: begin
        ps2_clk_out = 1'b0;
        ps2_dat_out = dat_q;
        tx_busy     = 1'b1;
      end
      SHIFT, ACK, WAITIDLE: begin
        ps2_dat_out = dat_q;
        tx_busy     = 1'b1;
      end
      DONE: begin
        tx_done  = 1'b1;
        tx_error = ack_n_q;
      end
      default: begin
        tx_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model that
// clocks the frame out and answers with ACK or NACK.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk28 = 1'b0;
  logic       rst_n;
  logic       dev_clk;
  logic       dev_dat;
  logic       clk_line;
  logic       dat_line;
  logic       ps2_clk_out;
  logic       ps2_dat_out;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk28 = ~clk28;

  assign clk_line = ps2_clk_out & dev_clk;
  assign dat_line = ps2_dat_out & dev_dat;

  ps2_host_tx dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .ps2_clk_in  (clk_line),
    .ps2_dat_in  (dat_line),
    .ps2_clk_out (ps2_clk_out),
    .ps2_dat_out (ps2_dat_out),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always @(negedge clk28) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  initial begin
`ifdef PS2_TX_TIMEOUT_EN
    #12_000_000;
`else
    #3_000_000;
`endif
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for tx_done and checks the status and line state around it.
  task automatic wait_done(input string tag, input logic exp_err);
    int   cyc;
    logic seen;
    logic prev_busy;
    cyc       = 0;
    seen      = 1'b0;
    prev_busy = tx_busy;
    while (!seen && cyc < 500) begin
      @(negedge clk28);
      cyc++;
      if (tx_done === 1'b1) seen = 1'b1;
      else prev_busy = tx_busy;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_error"}, 32'(tx_error), 32'(exp_err));
      check({tag, "_busy_at_done"}, 32'(tx_busy), 32'd0);
      check({tag, "_busy_before_done"}, 32'(prev_busy), 32'd1);
      check({tag, "_lines_released"}, 32'({ps2_clk_out, ps2_dat_out}), 32'h3);
      @(negedge clk28);
      check({tag, "_done_one_cycle"}, 32'(tx_done), 32'd0);
    end
  endtask

  // Keyboard model: bits 1..10 sampled at device clock rising edges, then the ack pulse.
  // abort_at > 0 asserts reset shortly after that device clock fall and returns.
  task automatic dev_frame(input logic ack_bit, input int abort_at, input bit busy_pulse,
                           input logic [10:0] fr_in, output logic [10:0] fr_out);
    logic [10:0] fr;
    fr = fr_in;
    for (int k = 1; k <= 10; k++) begin
      repeat (HALF) @(negedge clk28);
      dev_clk = 1'b0;
      if (k == abort_at) begin
        repeat (2) @(negedge clk28);
        check("rst_pre_dat_d3", 32'(ps2_dat_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_dat_released", 32'(ps2_dat_out), 32'd1);
        check("rst_clk_released", 32'(ps2_clk_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk28);
        rst_n = 1'b1;
        fr_out = fr;
        return;
      end
      if (busy_pulse && k == 3) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk28);
        tx_start = 1'b0;
        repeat (HALF - 1) @(negedge clk28);
      end else begin
        repeat (HALF) @(negedge clk28);
      end
      dev_clk = 1'b1;
      fr[k]   = dat_line;
    end
    repeat (HALF / 2) @(negedge clk28);
    dev_dat = ack_bit;
    repeat (HALF / 2) @(negedge clk28);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk28);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    fr_out  = fr;
  endtask

  // Starts a transfer, checks acceptance and the clock inhibit length; returns at clock release.
  task automatic start_xfer(input string tag, input logic [7:0] d, input int pulse_at);
    int cnt;
    @(negedge clk28);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk28);
    tx_start = 1'b0;
    check({tag, "_busy_n1"}, 32'(tx_busy), 32'd1);
    check({tag, "_clk_low_n1"}, 32'(ps2_clk_out), 32'd0);
    tx_data = ~d;
    cnt = 0;
    while (ps2_clk_out == 1'b0 && cnt < 6000) begin
      if (cnt == pulse_at) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk28);
      cnt++;
    end
    tx_start = 1'b0;
    check({tag, "_clk_low_cycles"}, 32'(cnt), 32'd2828);
  endtask

  task automatic do_xfer(input string tag, input logic [7:0] d, input logic [10:0] exp_frame,
                         input logic ack_bit, input int pulse_at, input bit busy_pulse);
    logic [10:0] fr0;
    logic [10:0] fr;
    int          dc0;
    dc0 = done_cnt;
    start_xfer(tag, d, pulse_at);
    fr0    = '0;
    fr0[0] = dat_line;
    dev_frame(ack_bit, 0, busy_pulse, fr0, fr);
    check({tag, "_frame"}, 32'(fr), 32'(exp_frame));
    wait_done(tag, ack_bit);
    repeat (50) @(negedge clk28);
    check({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    check({tag, "_idle_after"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    logic [10:0] fr;
    int          dc0;
    rst_n    = 1'b0;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    repeat (3) @(negedge clk28);
    check("reset_clk_out", 32'(ps2_clk_out), 32'd1);
    check("reset_dat_out", 32'(ps2_dat_out), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    check("reset_error", 32'(tx_error), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk28);

    // 0xF4 acked: start,d0..d7,parity 0,stop
    do_xfer("f4_ack", 8'hF4, 11'b101_1110_1000, 1'b0, -1, 1'b0);
    // 0x00 -> parity 1, 0x01 -> parity 0
    do_xfer("x00", 8'h00, 11'b110_0000_0000, 1'b0, -1, 1'b0);
    do_xfer("x01", 8'h01, 11'b100_0000_0010, 1'b0, -1, 1'b0);
    // 0xF3 with device leaving data high in the ack slot
    do_xfer("f3_nack", 8'hF3, 11'b111_1110_0110, 1'b1, -1, 1'b0);
    // 0xED with 0xFF requests during inhibit and during shifting
    do_xfer("ed_busy", 8'hED, 11'b111_1101_1010, 1'b0, 100, 1'b1);

    // Reset during the 5th device clock, then a normal transfer
    dc0 = done_cnt;
    start_xfer("rst_xfer", 8'hF4, -1);
    dev_frame(1'b0, 5, 1'b0, 11'h000, fr);
    repeat (300) @(negedge clk28);
    check("rst_no_done", 32'(done_cnt - dc0), 32'd0);
    check("rst_idle", 32'(tx_busy), 32'd0);
    do_xfer("f4_after_rst", 8'hF4, 11'b101_1110_1000, 1'b0, -1, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int   cnt;
      logic seen;
      start_xfer("to", 8'hF4, -1);
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 430000) begin
        @(negedge clk28);
        cnt++;
        if (tx_done === 1'b1) seen = 1'b1;
      end
      check("to_done_seen", 32'(seen), 32'd1);
      check("to_latency_in_window", 32'((cnt >= 419999) && (cnt <= 420001)), 32'd1);
      check("to_error", 32'(tx_error), 32'd1);
      check("to_lines_released", 32'({ps2_clk_out, ps2_dat_out}), 32'h3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
